// File: rtl/ej32_con_tx.sv
// ej32_con_tx: byte-wide console transmitter on the 8-bit memory bus.
//
// A bus write to DATA queues one byte in a TX FIFO. An 8N1 serialiser
// drains the FIFO onto txd, LSB first, CLK_DIV clk cycles per bit.
//
// Register window at BASE (byte offsets):
//   0 DATA  write: push byte (sets ovr if full)   read: 0
//   1 STAT  write: ignored    read: {count[4:0], busy, empty, full}
//   2 OVR   write: clear ovr  read: {7'b0, ovr}
//
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - asynchronous active-high reset
//   cs   - bus cycle select
//   we   - 1 = write, 0 = read (qualified by cs)
//   ai   - byte address, ASZ bits
//   vi   - write data byte
//   vo   - registered read data (0 unless hit)
//   hit  - registered, vo carries window read data this cycle
//   txd  - registered serial output, idle high
//   irq  - level, high while FIFO empty and transmitter idle
module ej32_con_tx #(
    parameter int unsigned BASE    = 'h1400,
    parameter int unsigned ASZ     = 17,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CLK_DIV = 868
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cs,
    input  logic           we,
    input  logic [ASZ-1:0] ai,
    input  logic [7:0]     vi,
    output logic [7:0]     vo,
    output logic           hit,
    output logic           txd,
    output logic           irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [ASZ-1:0] BASE_A   = ASZ'(BASE);
    localparam logic [4:0]     DEPTH_C  = 5'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------- state ----------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [4:0]    count_q, count_d;
    logic          ovr_q, ovr_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [7:0]    vo_q, vo_d;
    logic          hit_q, hit_d;

    // ---------------- bus decode ----------------
    // Unsigned wrap of the subtraction keeps addresses below BASE out of the window.
    logic [ASZ-1:0] off;
    logic           sel;
    logic           wr_data, wr_ovr, rd;
    logic           full, empty, busy;
    logic           push, pop;
    logic [7:0]     stat, rd_data;

    assign off     = ai - BASE_A;
    assign sel     = cs & (off < ASZ'(3));
    assign wr_data = sel & we & (off[1:0] == 2'd0);
    assign wr_ovr  = sel & we & (off[1:0] == 2'd2);
    assign rd      = sel & ~we;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == 5'd0);
    assign busy  = (state_q != S_IDLE);

    assign push = wr_data & ~full;
    assign pop  = (state_q == S_IDLE) & ~empty;

    assign stat = {count_q, busy, empty, full};

    always_comb begin
        rd_data = '0;
        case (off[1:0])
            2'd1:    rd_data = stat;
            2'd2:    rd_data = {7'b0, ovr_q};
            default: rd_data = '0;
        endcase
    end

    // ---------------- FIFO bookkeeping ----------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        count_d = count_q + {4'b0, push} - {4'b0, pop};
        // A full-FIFO write is dropped even if a pop frees a slot this cycle.
        if (wr_ovr)                ovr_d = 1'b0;
        if (wr_data && full)       ovr_d = 1'b1;
    end

    // ---------------- TX FSM ----------------
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    shift_d = mem_q[head_q];
                    div_d   = DIV_LAST;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    div_d   = DIV_LAST;
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            S_DATA: begin
                if (div_q == '0) begin
                    div_d = DIV_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            S_STOP: begin
                if (div_q == '0) state_d = S_IDLE;
                else             div_d   = div_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // txd follows the current state one cycle later (registered line driver).
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        hit_d = rd;
        vo_d  = rd ? rd_data : '0;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= vi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            vo_q    <= '0;
            hit_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            vo_q    <= vo_d;
            hit_q   <= hit_d;
        end
    end

    assign vo  = vo_q;
    assign hit = hit_q;
    assign txd = txd_q;
    assign irq = empty & ~busy;

endmodule

// File: tb/tb_ej32_con_tx.sv
// Directed bench for ej32_con_tx with CLK_DIV=4, DEPTH=16.
module tb_ej32_con_tx;

    localparam logic [16:0] BASE = 17'h1400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs  = 1'b0;
    logic        we  = 1'b0;
    logic [16:0] ai  = '0;
    logic [7:0]  vi  = '0;
    logic [7:0]  vo;
    logic        hit, txd, irq;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    ej32_con_tx #(
        .BASE(32'h1400),
        .ASZ(17),
        .DEPTH(16),
        .CLK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .ai(ai), .vi(vi),
        .vo(vo), .hit(hit), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    typedef struct {
        logic        cs;
        logic        we;
        logic [16:0] a;
        logic [7:0]  v;
        logic        hit;
        logic [7:0]  vo;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive at a negedge, the posedge in between samples it,
    // registered read results are visible at the following negedge.
    task automatic bus(input logic c, input logic w, input logic [16:0] a, input logic [7:0] v);
        cs = c; we = w; ai = a; vi = v;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic wait_edge(input int unsigned e);
        if (cyc > e) check("schedule", cyc, e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst txd", txd, 1'b1);
        check("rst irq", irq, 1'b1);
        check("rst hit", hit, 1'b0);
        check("rst vo",  vo,  8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Frames popped at p0, p0+41, ...; relative to each pop edge: txd low for
    // edges +1..+4, data bits at +5..+36, high +37..+41 (stop + 1 idle cycle).
    task automatic check_stream(input logic [7:0] b [32], input int n, input int unsigned p0);
        int unsigned errs;
        logic [7:0]  rx;
        logic        exp_t, exp_i;
        logic [7:0]  cur;
        for (int k = 0; k < n; k++) begin
            errs = 0;
            rx   = '0;
            cur  = b[k];
            for (int r = 1; r <= 41; r++) begin
                wait_edge(p0 + 41 * k + r);
                if (r <= 4)       exp_t = 1'b0;
                else if (r <= 36) exp_t = cur[(r - 5) / 4];
                else              exp_t = 1'b1;
                exp_i = (k == n - 1) && (r >= 40);
                if (txd !== exp_t || irq !== exp_i) errs++;
                if (r >= 5 && r <= 36 && ((r - 5) % 4) == 2) rx[(r - 5) / 4] = txd;
            end
            check("frame byte", rx, b[k]);
            check("frame timing", errs, 0);
        end
    endtask

    logic [7:0]  bytes [32];
    int unsigned c, e0, p0, lows;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, BASE + 17'd1, 8'h00, 1'b1, 8'h02};
        tbl[1]  = '{1'b1, 1'b0, BASE + 17'd3, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, BASE + 17'd2, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, BASE,         8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, BASE + 17'd1, 8'h00, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, BASE - 17'd1, 8'h00, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, BASE + 17'd1, 8'hFF, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, BASE + 17'd1, 8'h00, 1'b1, 8'h02};
        tbl[8]  = '{1'b1, 1'b1, BASE + 17'd2, 8'h5A, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, BASE + 17'd2, 8'h00, 1'b1, 8'h00};
        tbl[10] = '{1'b1, 1'b1, BASE,         8'h3C, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 1'b0, BASE + 17'd1, 8'h00, 1'b1, 8'h08};
        tbl[12] = '{1'b1, 1'b0, BASE + 17'd1, 8'h00, 1'b1, 8'h06};
        tbl[13] = '{1'b1, 1'b0, BASE + 17'd2, 8'h00, 1'b1, 8'h00};

        // ---- register window vectors ----
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus(tbl[i].cs, tbl[i].we, tbl[i].a, tbl[i].v);
            check("vec hit", hit, tbl[i].hit);
            check("vec vo",  vo,  tbl[i].vo);
        end

        // ---- single frame 'h41, irq timing ----
        do_reset();
        c = cyc;
        bus(1'b1, 1'b1, BASE, 8'h41);
        check("irq after write", irq, 1'b0);
        check("txd after write", txd, 1'b1);
        bytes[0] = 8'h41;
        check_stream(bytes, 1, c + 2);
        check("irq after frame", irq, 1'b1);

        // ---- fill while stalled, overflow, clear, push on full+pop ----
        do_reset();
        c  = cyc;
        e0 = c + 1;
        bus(1'b1, 1'b1, BASE, 8'h11);
        for (int i = 0; i < 17; i++) bus(1'b1, 1'b1, BASE, 8'h20 + 8'(i));
        bus(1'b1, 1'b0, BASE + 17'd1, 8'h00);
        check("stat full", vo, 8'h85);
        bus(1'b1, 1'b0, BASE + 17'd2, 8'h00);
        check("ovr set", vo, 8'h01);
        bus(1'b1, 1'b1, BASE + 17'd2, 8'h77);
        bus(1'b1, 1'b0, BASE + 17'd2, 8'h00);
        check("ovr cleared", vo, 8'h00);
        wait_edge(e0 + 41);
        bus(1'b1, 1'b1, BASE, 8'hEE);
        bus(1'b1, 1'b0, BASE + 17'd1, 8'h00);
        check("stat push+pop full", vo, 8'h7C);
        bus(1'b1, 1'b0, BASE + 17'd2, 8'h00);
        check("ovr on full+pop", vo, 8'h01);

        // ---- back-to-back frames, 20 writes, pointer wrap ----
        do_reset();
        bytes[0] = 8'h55;
        bytes[1] = 8'hAA;
        for (int i = 2; i < 17; i++) bytes[i] = 8'h10 + 8'(i);
        bytes[17] = 8'h01;
        bytes[18] = 8'h80;
        bytes[19] = 8'hFE;
        c  = cyc;
        e0 = c + 1;
        p0 = e0 + 1;
        fork
            begin
                for (int i = 0; i < 17; i++) bus(1'b1, 1'b1, BASE, bytes[i]);
                wait_edge(e0 + 124);
                for (int i = 17; i < 20; i++) bus(1'b1, 1'b1, BASE, bytes[i]);
            end
            check_stream(bytes, 20, p0);
        join
        bus(1'b1, 1'b0, BASE + 17'd1, 8'h00);
        check("stat drained", vo, 8'h02);
        bus(1'b1, 1'b0, BASE + 17'd2, 8'h00);
        check("ovr after stream", vo, 8'h00);

        // ---- reset during data bit 3 ----
        do_reset();
        c = cyc;
        bus(1'b1, 1'b1, BASE, 8'h00);
        bus(1'b1, 1'b1, BASE, 8'h00);
        wait_edge(c + 2 + 18);
        check("bit3 low", txd, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid rst txd", txd, 1'b1);
        check("mid rst irq", irq, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus(1'b1, 1'b0, BASE + 17'd1, 8'h00);
        check("stat after rst hit", hit, 1'b1);
        check("stat after rst", vo, 8'h02);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("no frame after rst", lows, 0);
        check("irq idle after rst", irq, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
